// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the seven-segment scan path
package seg_pkg;
    localparam int SEG_NIBBLE_W   = 4;
    localparam int DEF_NUM_DIGITS = 8;
    localparam int DIGIT_IDX_W    = $clog2(DEF_NUM_DIGITS);
    localparam logic [DEF_NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;
endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - free-running slot prescaler, ticks on the last cycle of each slot
module scan_prescaler #(
    parameter int CLK_DIV = 50000,
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic             tick,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick  = (r_count == CNT_W'(CLK_DIV - 1));
    assign count = r_count;
endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - tear-free 8-digit scan stage feeding the single seven-segment decoder
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic [SEG_NIBBLE_W*NUM_DIGITS-1:0] Data,
    input  logic                               Load,
    input  logic [NUM_DIGITS-1:0]              DigitMask,
    output logic [SEG_NIBBLE_W-1:0]            Digit,
    output logic                               EnableSegs,
    output logic [NUM_DIGITS-1:0]              Anode,
    output logic                               FrameStart
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DATA_W = SEG_NIBBLE_W * NUM_DIGITS;

    logic                    w_tick;
    logic [CNT_W-1:0]        w_count;
    logic                    w_wrap;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_lzb;
    logic [SEG_NIBBLE_W-1:0] w_digit;
    logic [NUM_DIGITS-1:0]   w_anode;

    logic [IDX_W-1:0]        r_idx;
    logic [DATA_W-1:0]       r_shadow;
    logic [DATA_W-1:0]       r_disp;
    logic                    r_pending;
    logic [SEG_NIBBLE_W-1:0] r_digit;
    logic                    r_enable;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_frame_start;

    scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .Clk   (Clk),
        .Reset (Reset),
        .tick  (w_tick),
        .count (w_count)
    );

    assign w_wrap = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
    logic w_zero_above;

    // Walk down from the top nibble; digit 0 is left out so a zero value still shows "0".
    always_comb begin
        w_lzb        = '0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_disp[SEG_NIBBLE_W*i +: SEG_NIBBLE_W] == '0);
            w_lzb[i]     = w_zero_above;
        end
    end
`else
    assign w_lzb = '0;
`endif

    assign w_blank = DigitMask[r_idx] | w_lzb[r_idx];
    assign w_digit = r_disp[SEG_NIBBLE_W*r_idx +: SEG_NIBBLE_W];
    assign w_anode = ((int'(w_count) < BLANK_CYC) || w_blank) ? '1
                   : ~(NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_idx <= '0;
        end else if (w_wrap) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // disp only changes on a frame boundary so a frame never mixes two values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else if (w_wrap && Load) begin
            r_shadow  <= Data;
            r_disp    <= Data;
            r_pending <= 1'b0;
        end else if (w_wrap && r_pending) begin
            r_disp    <= r_shadow;
            r_pending <= 1'b0;
        end else if (Load) begin
            r_shadow  <= Data;
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_digit       <= '0;
            r_enable      <= 1'b0;
            r_anode       <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_digit       <= w_digit;
            r_enable      <= !w_blank;
            r_anode       <= w_anode;
            r_frame_start <= w_wrap;
        end
    end

    assign Digit      = r_digit;
    assign EnableSegs = r_enable;
    assign Anode      = r_anode;
    assign FrameStart = r_frame_start;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard bench for seven_seg_scan with CLK_DIV=4, BLANK_CYC=1
module tb_seven_seg_scan;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Load = 1'b0;
    logic [31:0] Data = '0;
    logic [7:0]  DigitMask = '0;
    logic [3:0]  Digit;
    logic        EnableSegs;
    logic [7:0]  Anode;
    logic        FrameStart;

    always #5 Clk = ~Clk;

    seven_seg_scan #(.NUM_DIGITS(8), .CLK_DIV(4), .BLANK_CYC(1)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Data       (Data),
        .Load       (Load),
        .DigitMask  (DigitMask),
        .Digit      (Digit),
        .EnableSegs (EnableSegs),
        .Anode      (Anode),
        .FrameStart (FrameStart)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] EN_ZERO = 8'h01;
    localparam logic [7:0] EN_BEEF = 8'h0F;
    localparam logic [7:0] EN_120  = 8'h07;
`else
    localparam logic [7:0] EN_ZERO = 8'hFF;
    localparam logic [7:0] EN_BEEF = 8'hFF;
    localparam logic [7:0] EN_120  = 8'hFF;
`endif

    typedef struct {
        int          frame;
        logic [31:0] digits;
        logic [7:0]  en;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_valid = 0;
    int   tests = 0;
    int   fails = 0;
    int   pos = 0;
    int   frame_no = 0;
    int   k = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s frame=%0d pos=%0d got=%h want=%h", name, frame_no, pos, act, req);
        end
    endtask

    // Each negedge sample is one output; pos/frame_no locate it within the scan frame.
    always @(negedge Clk) begin
        if (Reset) begin
            check("reset_anode", {24'h0, Anode}, 32'hFF);
            check("reset_enable", {31'h0, EnableSegs}, 32'h0);
            check("reset_digit", {28'h0, Digit}, 32'h0);
            check("reset_framestart", {31'h0, FrameStart}, 32'h0);
            pos       = 0;
            frame_no  = 0;
            cur_valid = 0;
        end else begin
            if (pos == 0) begin
                cur_valid = 0;
                while (exp_q.size() > 0 && exp_q[0].frame < frame_no) begin
                    tests++;
                    fails++;
                    $display("FAIL stale_expect frame=%0d tag=%0d", frame_no, exp_q[0].frame);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].frame == frame_no) begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1;
                end
            end
            check("framestart", {31'h0, FrameStart}, (pos == 31) ? 32'h1 : 32'h0);
            if (cur_valid) begin
                int         slot;
                int         phase;
                logic [7:0] one;
                logic [7:0] a_exp;
                slot  = pos / 4;
                phase = pos % 4;
                one   = 8'h01;
                a_exp = (phase == 0 || !cur.en[slot]) ? 8'hFF : ~(one << slot);
                check("digit", {28'h0, Digit}, {28'h0, cur.digits[4*slot +: 4]});
                check("enable", {31'h0, EnableSegs}, {31'h0, cur.en[slot]});
                check("anode", {24'h0, Anode}, {24'h0, a_exp});
            end
            if (pos == 31) begin
                pos = 0;
                frame_no++;
            end else begin
                pos++;
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
        k++;
    endtask

    task automatic go_to(input int target);
        while (k < target) step();
    endtask

    task automatic load(input logic [31:0] d);
        Load = 1'b1;
        Data = d;
        step();
        Load = 1'b0;
    endtask

    task automatic push(input int f, input logic [31:0] d, input logic [7:0] en);
        exp_t e;
        e.frame  = f;
        e.digits = d;
        e.en     = en;
        exp_q.push_back(e);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at k=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clk);
        #1;
        Reset = 1'b0;
        k     = 0;
        push(0, 32'h0, EN_ZERO);
        push(1, 32'h0, EN_ZERO);
        push(2, 32'h1234ABCD, 8'hFF);
        go_to(40);
        load(32'h1234ABCD);

        push(3, 32'h22222222, 8'hFF);
        go_to(70);
        load(32'h11111111);
        go_to(80);
        load(32'h22222222);

        // Load sampled on edge 128, the wrapping tick into frame 4.
        push(4, 32'h0000BEEF, EN_BEEF);
        push(5, 32'h0000BEEF, EN_BEEF);
        go_to(127);
        load(32'h0000BEEF);

        push(6, 32'h87654321, 8'hF0);
        go_to(170);
        load(32'h87654321);
        go_to(192);
        DigitMask = 8'h0F;

        push(7, 32'h87654321, 8'hFF);
        go_to(224);
        DigitMask = 8'h00;

        push(8, 32'h00000120, EN_120);
        go_to(230);
        load(32'h00000120);

        push(9, 32'h0, EN_ZERO);
        go_to(260);
        load(32'h0);

        push(10, 32'h0, EN_ZERO);
        go_to(322);
        load(32'h55555555);
        go_to(342);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        Reset = 1'b0;
        k     = 0;
        push(0, 32'h0, EN_ZERO);
        push(1, 32'h0, EN_ZERO);
        go_to(66);

        check("queue_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
